// File: rtl/sram_pkg.sv
// Shared types and widths for the 16-bit asynchronous SRAM controller.
// The range check is compiled in by defining SRAM_ADDR_CHECK_EN.
package sram_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam int WORD_AW = SRAM_AW - 1;
    localparam int WAIT_CW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/sram_wait_cnt.sv
// Wait-state counter: counts cycles within a half-access.
// tc is high on the last cycle of the half-access.
module sram_wait_cnt
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    logic [WAIT_CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clear)
            r_cnt <= '0;
        else if (enable)
            r_cnt <= r_cnt + 1'b1;
    end

    assign tc = (r_cnt == WAIT_CW'(WAIT_CYCLES - 1));
endmodule

// File: rtl/mem_sram_ctrl.sv
// Splits each 32-bit CPU access into two 16-bit SRAM half-accesses (LO then HI).
// Define SRAM_ADDR_CHECK_EN to reject out-of-range requests with addr_err.
module mem_sram_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic               addr_err,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_i,
    output logic               sram_we_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic [1:0]         dbg_state
);
    // Handshake: a request is held on rd_en/wr_en until ready is seen high
    // while the request is present; ready high with no request means idle.
    state_t              r_state, w_next;
    logic [WORD_AW-1:0]  r_word;
    logic [31:0]         r_wdata;
    logic                r_wr;
    logic [31:0]         w_offset;
    logic [WORD_AW-1:0]  w_word;
    logic                w_req, w_tc, w_busy, w_range_err, w_unused;

    assign w_req    = rd_en | wr_en;
    assign w_offset = address - ADDR_BASE;
    assign w_word   = w_offset[WORD_AW+1:2];
    assign w_busy   = (r_state == ST_LO) || (r_state == ST_HI);

`ifdef SRAM_ADDR_CHECK_EN
    logic r_err;
    assign w_range_err = (address < ADDR_BASE) || (|w_offset[31:WORD_AW+2]);
    assign w_unused    = ^w_offset[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (r_state == ST_IDLE && w_req)
            r_err <= w_range_err;
    end
    assign addr_err = (r_state == ST_DONE) && r_err;
`else
    assign w_range_err = 1'b0;
    assign w_unused    = ^{w_offset[31:WORD_AW+2], w_offset[1:0]};
    assign addr_err    = 1'b0;
`endif

    sram_wait_cnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (!w_busy || w_tc),
        .enable (w_busy),
        .tc     (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_next = w_range_err ? ST_DONE : ST_LO;
            ST_LO:   if (w_tc)  w_next = ST_HI;
            ST_HI:   if (w_tc)  w_next = ST_DONE;
            default:            w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready      = (r_state == ST_DONE) || (r_state == ST_IDLE && !w_req);
        sram_ce_n  = !w_busy;
        sram_oe_n  = !(w_busy && !r_wr);
        sram_we_n  = !(w_busy && r_wr);
        sram_dq_oe = w_busy && r_wr;
        sram_addr  = '0;
        sram_dq_o  = '0;
        if (r_state == ST_LO) begin
            sram_addr = {r_word, 1'b0};
            sram_dq_o = r_wdata[15:0];
        end else if (r_state == ST_HI) begin
            sram_addr = {r_word, 1'b1};
            sram_dq_o = r_wdata[31:16];
        end
    end

    // Request is latched once in IDLE; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_wdata   <= '0;
            r_wr      <= 1'b0;
            read_data <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_word  <= w_word;
                r_wdata <= write_data;
                r_wr    <= wr_en;
            end
            if (w_tc && !r_wr && r_state == ST_LO)
                read_data[15:0] <= sram_dq_i;
            if (w_tc && !r_wr && r_state == ST_HI)
                read_data[31:16] <= sram_dq_i;
        end
    end

    assign dbg_state = r_state;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized self-checking bench for mem_sram_ctrl against a behavioural SRAM model.
// Honours SRAM_ADDR_CHECK_EN when the build defines it.
module tb_mem_sram_ctrl;
  import sram_pkg::*;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, addr_err, sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic [1:0]  dbg_state;

  mem_sram_ctrl #(.ADDR_BASE(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .addr_err(addr_err),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural SRAM contents, also the reference for expected read data
  logic [15:0] mem [0:262143];
  assign sram_dq_i = (!sram_oe_n && !sram_ce_n) ? mem[sram_addr] : 16'h0000;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_rd;

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) >> 2;
    return d[16:0];
  endfunction

  function automatic bit range_err(input logic [31:0] a);
`ifdef SRAM_ADDR_CHECK_EN
    return (a < BASE) || (((a - BASE) >> 2) >= 32'h20000);
`else
    return (a == 32'hFFFF_FFFF) && (a == 32'h0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // idle strobes, sampled mid-cycle
  task automatic chk_quiet(input string tag);
    chk({tag, "_ce_n"}, sram_ce_n, 1'b1);
    chk({tag, "_we_n"}, sram_we_n, 1'b1);
    chk({tag, "_oe_n"}, sram_oe_n, 1'b1);
    chk({tag, "_dq_oe"}, sram_dq_oe, 1'b0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_ready", ready, 1'b1);
    chk_quiet("idle");
    @(posedge clk); #1;
  endtask

  // One CPU access; called just after a rising edge (its cycle 0).
  task automatic access(input bit do_rd, input bit do_wr, input logic [31:0] a, input logic [31:0] d);
    bit          is_wr, err, half;
    logic [16:0] w;
    is_wr = do_wr;
    err   = range_err(a);
    w     = word_of(a);
    rd_en = do_rd; wr_en = do_wr; address = a; write_data = d;
    @(negedge clk);
    chk("req_ready", ready, 1'b0);
    if (err) begin
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
      @(negedge clk);
      chk("err_ready", ready, 1'b1);
      chk("err_flag", addr_err, 1'b1);
      chk("err_rdata", read_data, exp_rd);
      chk_quiet("err");
    end else begin
      for (int k = 1; k <= 2 * W; k++) begin
        @(posedge clk); #1;
        if (k == 1) begin
          rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
        end
        @(negedge clk);
        half = (k > W);
        chk("busy_ready", ready, 1'b0);
        chk("sram_addr", sram_addr, {w, half});
        chk("busy_ce_n", sram_ce_n, 1'b0);
        chk("busy_oe_n", sram_oe_n, is_wr);
        chk("busy_we_n", sram_we_n, !is_wr);
        chk("busy_dq_oe", sram_dq_oe, is_wr);
        chk("busy_err", addr_err, 1'b0);
        if (is_wr) chk("dq_o", sram_dq_o, half ? d[31:16] : d[15:0]);
      end
      if (is_wr) begin
        mem[{w, 1'b0}] = d[15:0];
        mem[{w, 1'b1}] = d[31:16];
      end else begin
        exp_rd = {mem[{w, 1'b1}], mem[{w, 1'b0}]};
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_ready", ready, 1'b1);
      chk("done_err", addr_err, 1'b0);
      chk("done_rdata", read_data, exp_rd);
      chk_quiet("done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [16:0] w;
    int          op;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    exp_rd = 32'h0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'h0; write_data = 32'h0;

    // reset state
    #12;
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_err", addr_err, 1'b0);
    chk("rst_addr", sram_addr, 18'h0);
    chk("rst_dq_o", sram_dq_o, 16'h0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk_quiet("rst");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // directed: write then read back, first-word mapping
    access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
    idle_cycle();
    mem[2] = 16'h5678; mem[3] = 16'h1234;
    access(1'b1, 1'b0, 32'd1028, 32'h0);
    chk("rd_1028", read_data, 32'h1234_5678);
    idle_cycle();
    // both enables high is a write; read_data untouched
    access(1'b1, 1'b1, 32'd1024 + 32'd20, 32'hA5A5_5A5A);
    access(1'b1, 1'b0, 32'd1024 + 32'd22, 32'h0);
    // boundaries: top word, wrap past 2^17 words, below base
    access(1'b0, 1'b1, BASE + 32'h1FFFF * 4, 32'hCAFE_F00D);
    access(1'b1, 1'b0, BASE + 32'h1FFFF * 4 + 32'd3, 32'h0);
    access(1'b0, 1'b1, BASE + 32'h20001 * 4, 32'h1357_9BDF);
    access(1'b1, 1'b0, 32'd0, 32'h0);
    access(1'b1, 1'b0, BASE + 32'd4, 32'h0);

    // randomized mix, mostly back-to-back
    for (int n = 0; n < 30; n++) begin
      op = $urandom_range(0, 2);
      a  = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      d  = $urandom;
      access(op != 1, op != 0, a, d);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // reset in the HI phase of a write
    a = BASE + 32'd24; d = 32'h0BAD_F00D; w = word_of(a);
    rd_en = 1'b0; wr_en = 1'b1; address = a; write_data = d;
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < W; k++) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_hi", sram_addr, {w, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk_quiet("abort");
    chk("abort_ready", ready, 1'b1);
    chk("abort_addr", sram_addr, 18'h0);
    chk("abort_dq_o", sram_dq_o, 16'h0);
    chk("abort_rdata", read_data, 32'h0);
    mem[{w, 1'b0}] = d[15:0];
    exp_rd = 32'h0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle_cycle();
    access(1'b1, 1'b0, BASE + 32'd24, 32'h0);
    access(1'b1, 1'b0, BASE + 32'd20, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
